mic_zero_crossing_meter: RTL and testbench
==========================================

Name: mic_zero_crossing_meter

Overview:
- Sits directly downstream of the INMP441 I2S receiver and consumes its 24-bit signed sample word.
- Takes one sample per audio frame, tracks the waveform polarity with hysteresis and measures the period between rising zero crossings, in samples.
- Also reports the peak amplitude over each measured period and flags silence.
- Its outputs feed the pitch/note logic and the display.

Parameters:
- sample_clk, 1024: clk cycles per audio sample. Matches the receiver frame at 50 MHz; set to 2048 at 100 MHz.
- threshold, 24'd4096: hysteresis magnitude, positive, applied as ±threshold.
- max_period, 12'd2047: sample count at which the measurement times out and silence is declared.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- value  input  24  signed two's-complement sample from the I2S receiver; held between frames
- period  output  12  samples between the last two rising crossings
- period_valid  output  1  one-cycle pulse when period and level update
- level  output  8  peak |sample| over the last period, bits [22:15] of the peak
- silent  output  1  high when no valid crossing has occurred within max_period samples

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - period = 0, period_valid = 0, level = 0, silent = 1.
  - Polarity state = UNKNOWN, armed = 0.
  - Strobe counter = 0, sample counter = 0, peak = 0.
- Strobe:
  - Free-running counter 0..sample_clk-1, wrapping to 0.
  - strobe = 1 in the cycle the counter equals sample_clk-1.
  - value is read only in strobe cycles; it is not aligned to the receiver update, and the measurement does not depend on phase.
- Absolute value:
  - abs = |value|, saturated: 24'h800000 maps to 24'h7FFFFF.
  - Each strobe: peak <= max(peak, abs). Peak saturates and never wraps.
- Polarity FSM, evaluated on strobe only (s = signed value):
  - UNKNOWN: s >= threshold -> HIGH; s <= -threshold -> LOW. No crossing is recorded.
  - LOW: s >= threshold -> HIGH, and this is a rising crossing. Otherwise stay.
  - HIGH: s <= -threshold -> LOW. Otherwise stay.
  - Samples strictly inside (-threshold, +threshold) never change state.
- Sample counter:
  - Increments by 1 on each strobe that is not a rising crossing.
  - Saturates at max_period.
- Rising crossing strobe, armed = 1:
  - period <= counter + 1.
  - level <= peak_updated[22:15], where peak_updated includes the current sample.
  - period_valid pulses.
  - silent <= 0.
- Rising crossing strobe, armed = 0:
  - armed <= 1.
  - No output update and no pulse.
- On every rising crossing: counter <= 0 and peak <= 0.
- Result: crossings at strobes k and k+N give period = N.
- Timeout, on the strobe where the counter reaches max_period with no crossing:
  - silent <= 1, armed <= 0, FSM -> UNKNOWN, peak <= 0, counter held at max_period.
  - period and level keep their last values.
- After a timeout, two rising crossings are needed before the next period_valid.
- Latency: outputs are registered and change in the cycle after the strobe. period_valid is high for exactly that one cycle.
- Priority: a crossing and a timeout on the same strobe are resolved as the crossing; timeout is not applied.
- Reset mid-measurement: all state returns to reset values the next cycle. No pulse is emitted during or after reset until two crossings have been seen.

Test Plan:
- Square wave, +0x010000 for 20 samples then -0x010000 for 20, repeated:
  - First rising crossing arms only.
  - Every later crossing gives period = 40, level = 0x02, period_valid 1 cycle; silent falls at the first pulse.
- Amplitude ±0x000800, below threshold, for 2100 samples:
  - No period_valid; silent stays 1; period = 0.
- Established 40-sample tone, then value held at 0:
  - silent rises exactly 2047 strobes after the last crossing.
  - period stays 40; tone restart needs 2 crossings before a pulse.
- Alternating ±0x001001, one sample per polarity:
  - period = 2, pulse every 2 strobes.
  - Then ±0x000FFF: no state change and no further pulses.
- Tone of -0x800000 / +0x000FFF... replaced: tone of -0x800000 / +0x7FFFFF with 16-sample half cycles:
  - level = 0xFF (saturated abs), period = 32.
- Assert rst for 1 cycle in the middle of a 40-sample tone:
  - Outputs return to 0/0/0/1.
  - First pulse after reset occurs on the second rising crossing, with period = 40.

Source files
------------

// File: rtl/mic_zero_crossing_meter.sv
// Zero-crossing period meter for the INMP441 sample stream: hysteretic polarity
// tracking, period between rising crossings, per-period peak level and silence flag.
module mic_zero_crossing_meter #(
    parameter int unsigned sample_clk = 1024,
    parameter logic [23:0] threshold  = 24'd4096,
    parameter logic [11:0] max_period = 12'd2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] value,
    output logic [11:0] period,
    output logic        period_valid,
    output logic [7:0]  level,
    output logic        silent
);

    localparam int unsigned     sc_w    = (sample_clk > 1) ? $clog2(sample_clk) : 1;
    localparam logic [sc_w-1:0] sc_last = sc_w'(sample_clk - 1);
    localparam logic signed [23:0] pos_th = $signed(threshold);
    localparam logic signed [23:0] neg_th = -$signed(threshold);

    typedef enum logic [1:0] {
        UNKNOWN,
        LOW,
        HIGH
    } pol_t;

    pol_t              state;
    pol_t              state_next;
    logic [sc_w-1:0]   strobe_cnt;
    logic              strobe;
    logic [11:0]       sample_cnt;
    logic [23:0]       peak;
    logic [23:0]       abs_val;
    logic [23:0]       peak_upd;
    logic              armed;
    logic signed [23:0] s;
    logic              above;
    logic              below;
    logic              rising;
    logic              timeout;

    assign s        = $signed(value);
    assign above    = (s >= pos_th);
    assign below    = (s <= neg_th);
    assign strobe   = (strobe_cnt == sc_last);
    assign peak_upd = (abs_val > peak) ? abs_val : peak;
    assign rising   = strobe && (state == LOW) && above;
    // A crossing on the timeout strobe wins, so the timeout is masked by rising.
    assign timeout  = strobe && !rising && (sample_cnt == max_period - 12'd1);

    // The most negative code has no positive twin, so it clamps to full scale.
    always_comb begin
        abs_val = value;
        if (value[23]) begin
            abs_val = (value == 24'h800000) ? 24'h7FFFFF : -value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNKNOWN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (strobe) begin
            if (timeout) begin
                state_next = UNKNOWN;
            end else begin
                case (state)
                    UNKNOWN: begin
                        if (above) begin
                            state_next = HIGH;
                        end else if (below) begin
                            state_next = LOW;
                        end
                    end
                    LOW: begin
                        if (above) begin
                            state_next = HIGH;
                        end
                    end
                    HIGH: begin
                        if (below) begin
                            state_next = LOW;
                        end
                    end
                    default: state_next = UNKNOWN;
                endcase
            end
        end
    end

    // The first rising crossing after reset or timeout only arms the measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_cnt   <= '0;
            sample_cnt   <= '0;
            peak         <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            level        <= '0;
            silent       <= 1'b1;
        end else begin
            period_valid <= 1'b0;
            strobe_cnt   <= strobe ? '0 : strobe_cnt + 1'b1;
            if (strobe) begin
                if (rising) begin
                    sample_cnt <= '0;
                    peak       <= '0;
                    if (armed) begin
                        period       <= sample_cnt + 12'd1;
                        level        <= peak_upd[22:15];
                        period_valid <= 1'b1;
                        silent       <= 1'b0;
                    end else begin
                        armed <= 1'b1;
                    end
                end else if (timeout) begin
                    silent     <= 1'b1;
                    armed      <= 1'b0;
                    peak       <= '0;
                    sample_cnt <= max_period;
                end else begin
                    peak <= peak_upd;
                    if (sample_cnt < max_period) begin
                        sample_cnt <= sample_cnt + 12'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mic_zero_crossing_meter.sv
// Directed bench for mic_zero_crossing_meter with a short sample period so
// silence timeouts and long tones fit in a brief run.
module tb_mic_zero_crossing_meter;

    localparam int SC = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [23:0] value = 24'd0;
    logic [11:0] period;
    logic        period_valid;
    logic [7:0]  level;
    logic        silent;

    int compared   = 0;
    int mismatched = 0;

    int          pulse_count = 0;
    int          double_count = 0;
    int          base = 0;
    logic [11:0] last_period = '0;
    logic [7:0]  last_level = '0;
    logic        prev_valid = 1'b0;
    logic        prev_silent = 1'b1;
    logic        seen_first = 1'b0;
    logic        silent_before_first = 1'b0;

    mic_zero_crossing_meter #(
        .sample_clk(SC),
        .threshold (24'd4096),
        .max_period(12'd2047)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .period      (period),
        .period_valid(period_valid),
        .level       (level),
        .silent      (silent)
    );

    always #5 clk = ~clk;

    // Pulse monitor: records every period_valid pulse and any pulse wider than one cycle.
    always @(negedge clk) begin
        if (period_valid) begin
            pulse_count = pulse_count + 1;
            last_period = period;
            last_level  = level;
            if (!seen_first) begin
                seen_first          = 1'b1;
                silent_before_first = prev_silent;
            end
            if (prev_valid) double_count = double_count + 1;
        end
        prev_valid  = period_valid;
        prev_silent = silent;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared = compared + 1;
        if (got !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Any SC consecutive rising edges contain exactly one strobe, whatever the phase.
    task automatic applyStimulus(input logic [23:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            value = v;
            repeat (SC) @(negedge clk);
        end
    endtask

    task automatic playTone(input logic [23:0] first, input logic [23:0] second,
                            input int half, input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            applyStimulus((((i / half) % 2) == 0) ? first : second, 1);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_period", 32'(period), 32'd0);
        checkOutput("reset_valid", 32'(period_valid), 32'd0);
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_silent", 32'(silent), 32'd1);
        rst = 1'b0;

        // 40-sample square wave: crossings at 40 (arm), 80, 120, 160.
        base = pulse_count;
        playTone(24'h010000, 24'hFF0000, 20, 0, 161);
        #1;
        checkOutput("sq_pulses", 32'(pulse_count - base), 32'd3);
        checkOutput("sq_period", 32'(last_period), 32'd40);
        checkOutput("sq_level", 32'(last_level), 32'h02);
        checkOutput("sq_silent", 32'(silent), 32'd0);
        checkOutput("sq_silent_before_pulse", 32'(silent_before_first), 32'd1);

        // Silence: timeout lands exactly 2047 samples after the last crossing.
        base = pulse_count;
        applyStimulus(24'd0, 2046);
        #1;
        checkOutput("to_silent_2046", 32'(silent), 32'd0);
        applyStimulus(24'd0, 1);
        #1;
        checkOutput("to_silent_2047", 32'(silent), 32'd1);
        checkOutput("to_period_kept", 32'(period), 32'd40);
        checkOutput("to_level_kept", 32'(level), 32'h02);
        checkOutput("to_no_pulse", 32'(pulse_count - base), 32'd0);

        // Restart after timeout needs two rising crossings.
        base = pulse_count;
        playTone(24'h010000, 24'hFF0000, 20, 0, 41);
        #1;
        checkOutput("rs_armed_only", 32'(pulse_count - base), 32'd0);
        playTone(24'h010000, 24'hFF0000, 20, 41, 40);
        #1;
        checkOutput("rs_pulses", 32'(pulse_count - base), 32'd1);
        checkOutput("rs_period", 32'(last_period), 32'd40);
        checkOutput("rs_silent", 32'(silent), 32'd0);

        // Sub-threshold tone never leaves UNKNOWN.
        doReset();
        base = pulse_count;
        playTone(24'h000800, 24'hFFF800, 20, 0, 2100);
        #1;
        checkOutput("lo_pulses", 32'(pulse_count - base), 32'd0);
        checkOutput("lo_silent", 32'(silent), 32'd1);
        checkOutput("lo_period", 32'(period), 32'd0);

        // Just above threshold, one sample per polarity: crossings at 2,4,..,18.
        base = pulse_count;
        playTone(24'h001001, 24'hFFEFFF, 1, 0, 20);
        #1;
        checkOutput("alt_pulses", 32'(pulse_count - base), 32'd8);
        checkOutput("alt_period", 32'(last_period), 32'd2);
        checkOutput("alt_level", 32'(last_level), 32'h00);
        // Just inside the band: state stays LOW, so the next +0x1001 crosses 22 samples on.
        base = pulse_count;
        playTone(24'h000FFF, 24'hFFF001, 1, 0, 20);
        #1;
        checkOutput("band_no_pulse", 32'(pulse_count - base), 32'd0);
        applyStimulus(24'h001001, 1);
        #1;
        checkOutput("band_exit_pulse", 32'(pulse_count - base), 32'd1);
        checkOutput("band_exit_period", 32'(last_period), 32'd22);

        // Full-scale tone: the most negative code saturates to level 0xFF.
        doReset();
        base = pulse_count;
        playTone(24'h800000, 24'h7FFFFF, 16, 0, 97);
        #1;
        checkOutput("sat_pulses", 32'(pulse_count - base), 32'd2);
        checkOutput("sat_period", 32'(last_period), 32'd32);
        checkOutput("sat_level", 32'(last_level), 32'hFF);

        // One-cycle reset in the middle of an established tone.
        doReset();
        playTone(24'h010000, 24'hFF0000, 20, 0, 100);
        #1;
        checkOutput("mr_pre_silent", 32'(silent), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mr_period", 32'(period), 32'd0);
        checkOutput("mr_valid", 32'(period_valid), 32'd0);
        checkOutput("mr_level", 32'(level), 32'd0);
        checkOutput("mr_silent", 32'(silent), 32'd1);
        base = pulse_count;
        playTone(24'h010000, 24'hFF0000, 20, 100, 60);
        #1;
        checkOutput("mr_first_cross_arms", 32'(pulse_count - base), 32'd0);
        playTone(24'h010000, 24'hFF0000, 20, 160, 21);
        #1;
        checkOutput("mr_pulses", 32'(pulse_count - base), 32'd1);
        checkOutput("mr_period_after", 32'(last_period), 32'd40);
        checkOutput("mr_level_after", 32'(last_level), 32'h02);

        checkOutput("pulse_width_one_cycle", 32'(double_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
